approx_err_monitor: RTL
=======================

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the sample and error counters.
REQ-002 SHALL have parameter ACC_W, default 32, width of the summed error-distance accumulator.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a measurement run.
REQ-006 SHALL have port num_samples  input  CNT_W  run length, latched on an accepted start.
REQ-007 SHALL have port in_valid  input  1  a, b and y_approx are valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port a  input  8  multiplicand fed to the 8x8 approximate multiplier.
REQ-010 SHALL have port b  input  8  multiplier operand fed to the 8x8 approximate multiplier.
REQ-011 SHALL have port y_approx  input  16  product returned by the 8x8 approximate multiplier.
REQ-012 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-013 SHALL have port done  output  1  high in DONE; results are final.
REQ-014 SHALL have port sample_cnt  output  CNT_W  samples accumulated this run.
REQ-015 SHALL have port err_cnt  output  CNT_W  samples with nonzero error distance.
REQ-016 SHALL have port sum_ed  output  ACC_W  sum of error distances, saturating.
REQ-017 SHALL have port max_ed  output  16  largest error distance this run.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 SHALL, on start in IDLE or DONE, latch num_samples, clear all result outputs and the accept counter, and enter RUN; start in RUN or DRAIN SHALL be ignored.
REQ-020 SHALL drive in_ready high only in RUN while accepted count < latched num_samples.
REQ-021 SHALL accept a sample on a rising edge where in_valid and in_ready are both high; in_valid with in_ready low SHALL have no effect.
REQ-022 SHALL move RUN -> DRAIN on the edge that accepts the last sample, or on the first RUN cycle if latched num_samples is 0.
REQ-023 SHALL move DRAIN -> DONE on the first edge where both pipeline stages are empty; DONE SHALL hold until start or rst.
REQ-024 Stage 1 SHALL register the exact 16-bit product a*b, y_approx and a valid bit on acceptance.
REQ-025 Stage 2 SHALL compute ED = |exact - y_approx| as an unsigned 16-bit value and update results on the next edge.
REQ-026 A sample accepted at edge k SHALL be reflected in the result outputs after edge k+2.
REQ-027 SHALL increment sample_cnt by 1 per stage-2 update, and err_cnt by 1 when ED != 0.
REQ-028 SHALL add ED to sum_ed, saturating at 2^ACC_W-1 without wrapping.
REQ-029 SHALL update max_ed to ED when ED > max_ed.
REQ-030 SHALL sustain one accepted sample per cycle with no bubbles while in_valid stays high.

Reset
REQ-031 SHALL, on rst high, immediately force IDLE, clear both pipeline valid bits, and drive in_ready, busy, done, sample_cnt, err_cnt, sum_ed and max_ed to 0, regardless of current state.
REQ-032 SHALL discard in-flight samples on rst mid-run; the first start after rst releases SHALL begin a clean run.

Verification
REQ-033 The bench SHALL cover a basic run: start with num_samples=3; samples (15,15,225), (255,255,65025), (2,3,7) on consecutive cycles -> in_ready low after the third accept; then sample_cnt=3, err_cnt=1, sum_ed=1, max_ed=1, done=1.
REQ-034 The bench SHALL cover a zero-length run: start with num_samples=0 -> in_ready never high; done=1 within 3 cycles; all results 0.
REQ-035 The bench SHALL cover gaps and overrun: num_samples=2 with in_valid toggling 1,0,0,1,1 -> exactly 2 samples accepted; the fifth valid is ignored; sample_cnt=2.
REQ-036 The bench SHALL cover saturation: ACC_W=8, two samples each with y_approx=0 and a*b=200 -> sum_ed=255, max_ed=200, err_cnt=2.
REQ-037 The bench SHALL cover reset and restart: rst asserted in RUN after 1 accept -> all outputs 0 in IDLE; then start with num_samples=1 and sample (4,4,16) -> sample_cnt=1, err_cnt=0, done=1.
REQ-038 The bench SHALL cover start while busy: start pulsed in RUN with a different num_samples -> ignored; the run completes using the originally latched count.

Source files
------------

// File: rtl/approx_err_monitor.sv
// Error-distance monitor for an 8x8 approximate multiplier: compares each
// returned product against the exact one and gathers run statistics.
module approx_err_monitor #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      y_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [15:0]      max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Wide enough to hold the accumulator plus one 16-bit distance without overflow.
  localparam int SW = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam logic [SW-1:0] SAT_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_t state_q, state_d;

  logic [CNT_W-1:0] num_q, acc_cnt_q;
  logic             s1_valid_q;
  logic [15:0]      s1_exact_q, s1_approx_q;
  logic             s2_valid_q;
  logic [15:0]      s2_ed_q;
  logic [15:0]      ed_d;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [15:0]      max_ed_q, max_ed_d;
  logic [SW-1:0]    sum_wide;

  logic start_ok, accept, last_accept, pipe_empty;

  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == num_q);
  assign pipe_empty  = !s1_valid_q && !s2_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      // acc_cnt_q == num_q here only happens for a zero-length run.
      RUN:        if (last_accept || (acc_cnt_q == num_q)) state_d = DRAIN;
      DRAIN:      if (pipe_empty) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    in_ready = (state_q == RUN) && (acc_cnt_q < num_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q     <= '0;
      acc_cnt_q <= '0;
    end else if (start_ok) begin
      num_q     <= num_samples;
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  assign ed_d = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                            : (s1_approx_q - s1_exact_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_ed_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      if (accept) begin
        s1_exact_q  <= 16'(a) * 16'(b);
        s1_approx_q <= y_approx;
      end
      if (s1_valid_q) begin
        s2_ed_q <= ed_d;
      end
    end
  end

  assign sum_wide = SW'(sum_ed_q) + SW'(s2_ed_q);

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    if (start_ok) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sum_ed_d     = '0;
      max_ed_d     = '0;
    end else if (s2_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (s2_ed_q != 16'd0) err_cnt_d = err_cnt_q + CNT_W'(1);
      sum_ed_d = (sum_wide > SAT_MAX) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
      if (s2_ed_q > max_ed_q) max_ed_d = s2_ed_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;

endmodule
